// File: rtl/vs_abs_argmax_seq_if.sv
// Bus bundle for the absolute-argmax sequencer: scan control, result and the
// synchronous-read memory port, viewed as slave by the sequencer and master by its user.
interface vs_abs_argmax_seq_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              busy;
    logic              done;
    logic              empty;
    logic [31:0]       max_value;
    logic [ADDR_W-1:0] max_index;

    modport slave (
        input  start, abort, base_addr, length, rd_data,
        output rd_en, rd_addr, busy, done, empty, max_value, max_index
    );

    modport master (
        output start, abort, base_addr, length, rd_data,
        input  rd_en, rd_addr, busy, done, empty, max_value, max_index
    );
endinterface

// File: rtl/vs_abs_argmax_seq.sv
// Streams LENGTH words from a synchronous-read memory and reports the largest |x|
// together with its offset from the base address (first occurrence wins ties).
module vs_abs_argmax_seq #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  resetN,
    vs_abs_argmax_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [RD_LATENCY-1:0] LAST_STAGE = RD_LATENCY'(1) << (RD_LATENCY - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic [31:0]         r_runMax;
    logic [ADDR_W-1:0]   r_runIdx;
    logic [ADDR_W-1:0]   r_dataIdx;
    logic                r_isEmpty;
    logic [31:0]         r_maxValue;
    logic [ADDR_W-1:0]   r_maxIndex;

    logic                w_accept;
    logic                w_issuing;
    logic                w_lastIssue;
    logic                w_dataValid;
    logic [31:0]         w_absData;
    logic                w_update;
    logic [31:0]         w_newMax;
    logic [ADDR_W-1:0]   w_newIdx;
    logic                w_finish;

    // abort in the same IDLE cycle as start drops the request entirely
    assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_issuing   = (r_state == S_ISSUE);
    assign w_lastIssue = w_issuing && (r_remaining == (ADDR_W+1)'(1));
    assign w_dataValid = r_vpipe[RD_LATENCY-1];

    // the most negative value has no positive twin, so it saturates
    always_comb begin
        w_absData = bus.rd_data;
        if (bus.rd_data == 32'h8000_0000) begin
            w_absData = 32'h7FFF_FFFF;
        end else if (bus.rd_data[31]) begin
            w_absData = -bus.rd_data;
        end
    end

    assign w_update = w_dataValid && (w_absData > r_runMax);
    assign w_newMax = w_update ? w_absData : r_runMax;
    assign w_newIdx = w_update ? r_dataIdx : r_runIdx;
    assign w_finish = (r_state == S_DRAIN) && (w_nextState == S_DONE);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = (bus.length == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_lastIssue) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_vpipe == LAST_STAGE) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (bus.abort) begin
            w_nextState = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // valid pipeline mirrors the memory latency; abort discards in-flight reads
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_vpipe     <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_runMax    <= '0;
            r_runIdx    <= '0;
            r_dataIdx   <= '0;
            r_isEmpty   <= 1'b0;
            r_maxValue  <= '0;
            r_maxIndex  <= '0;
        end else begin
            r_vpipe <= bus.abort ? '0 : ((r_vpipe << 1) | RD_LATENCY'(w_issuing));

            if (w_accept) begin
                r_remaining <= bus.length;
                r_runMax    <= '0;
                r_runIdx    <= '0;
                r_dataIdx   <= '0;
                r_isEmpty   <= (bus.length == '0);
                if (bus.length != '0) begin
                    r_addr <= bus.base_addr;
                end
            end else begin
                if (w_issuing && !w_lastIssue && !bus.abort) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                if (w_issuing) begin
                    r_remaining <= r_remaining - (ADDR_W+1)'(1);
                end
                if (w_dataValid) begin
                    r_runMax  <= w_newMax;
                    r_runIdx  <= w_newIdx;
                    r_dataIdx <= r_dataIdx + ADDR_W'(1);
                end
            end

            // published result changes only on the edge that enters DONE
            if (w_finish) begin
                r_maxValue <= w_newMax;
                r_maxIndex <= w_newIdx;
            end else if (w_accept && (bus.length == '0)) begin
                r_maxValue <= '0;
                r_maxIndex <= '0;
            end
        end
    end

    assign bus.rd_en     = w_issuing;
    assign bus.rd_addr   = r_addr;
    assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.empty     = (r_state == S_DONE) && r_isEmpty;
    assign bus.max_value = r_maxValue;
    assign bus.max_index = r_maxIndex;

endmodule

// File: tb/tb_vs_abs_argmax_seq.sv
// Scoreboard bench: four sequencers with read latencies 1..4 share stimulus and memory
// contents; per-lane monitors check every read address and every done pulse.
module tb_vs_abs_argmax_seq;

    localparam int ADDR_W = 10;
    localparam int NLANE  = 4;

    typedef struct {
        logic [31:0] value;
        logic [9:0]  index;
        logic        empty;
        int          doneCycle;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start;
    logic        abort;
    logic [9:0]  baseAddr;
    logic [10:0] length;
    logic [31:0] mem [1024];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t        expQ  [NLANE][$];
    logic [9:0]  addrQ [NLANE][$];

    logic [NLANE-1:0]        laneRdEn, laneBusy, laneDone, laneEmpty;
    logic [NLANE-1:0][9:0]   laneRdAddr, laneMaxIndex;
    logic [NLANE-1:0][31:0]  laneMaxValue;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int laneIdx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s lane%0d (lat %0d) cycle %0d: got %h, expected %h",
                     name, laneIdx, laneIdx + 1, cyc, actual, expected);
        end
    endtask

    generate
        for (genvar g = 0; g < NLANE; g++) begin : lane
            localparam int LAT = g + 1;
            vs_abs_argmax_seq_if #(.ADDR_W(ADDR_W)) bus ();
            logic [31:0] dpipe [4];

            assign bus.start     = start;
            assign bus.abort     = abort;
            assign bus.base_addr = baseAddr;
            assign bus.length    = length;
            assign bus.rd_data   = dpipe[LAT-1];

            always @(posedge clock) begin
                dpipe[0] <= mem[bus.rd_addr];
                for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
            end

            vs_abs_argmax_seq #(.ADDR_W(ADDR_W), .RD_LATENCY(LAT)) dut (
                .clock (clock),
                .resetN(resetN),
                .bus   (bus)
            );

            assign laneRdEn[g]     = bus.rd_en;
            assign laneBusy[g]     = bus.busy;
            assign laneDone[g]     = bus.done;
            assign laneEmpty[g]    = bus.empty;
            assign laneRdAddr[g]   = bus.rd_addr;
            assign laneMaxIndex[g] = bus.max_index;
            assign laneMaxValue[g] = bus.max_value;

            always @(negedge clock) begin : monitor
                exp_t       e;
                logic [9:0] a;
                if (bus.done) begin
                    if (expQ[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL doneUnexpected lane%0d cycle %0d: got done=1, expected no done",
                                 g, cyc);
                    end else begin
                        e = expQ[g].pop_front();
                        checkOutput("doneCycle", g, 32'(cyc), 32'(e.doneCycle));
                        checkOutput("maxValue",  g, bus.max_value, e.value);
                        checkOutput("maxIndex",  g, 32'(bus.max_index), 32'(e.index));
                        checkOutput("empty",     g, 32'(bus.empty), 32'(e.empty));
                    end
                end
                if (bus.rd_en) begin
                    if (addrQ[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL readUnexpected lane%0d cycle %0d: got rd_en=1 addr %0d, expected rd_en=0",
                                 g, cyc, bus.rd_addr);
                    end else begin
                        a = addrQ[g].pop_front();
                        checkOutput("rdAddr", g, 32'(bus.rd_addr), 32'(a));
                    end
                end
            end
        end
    endgenerate

    // Pulses start in cycle t and queues the reads/result each lane should produce.
    task automatic applyStimulus(input logic [9:0] base, input logic [10:0] len, input int nReads,
                                 input bit expectDone, input logic [31:0] expVal,
                                 input logic [9:0] expIdx);
        int         t;
        exp_t       e;
        logic [9:0] a;
        @(posedge clock);
        #1;
        start    = 1'b1;
        baseAddr = base;
        length   = len;
        t        = cyc;
        for (int l = 0; l < NLANE; l++) begin
            for (int k = 0; k < nReads; k++) begin
                a = base + 10'(k);
                addrQ[l].push_back(a);
            end
            if (expectDone) begin
                e.value     = expVal;
                e.index     = expIdx;
                e.empty     = (len == 0);
                e.doneCycle = (len == 0) ? t + 1 : t + int'(len) + (l + 1) + 1;
                expQ[l].push_back(e);
            end
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int l = 0; l < NLANE; l++) checkOutput("busyAfterStart", l, 32'(laneBusy[l]), 32'(len != 0));
    endtask

    task automatic checkResetState();
        for (int l = 0; l < NLANE; l++) begin
            checkOutput("rstRdEn",     l, 32'(laneRdEn[l]), 32'd0);
            checkOutput("rstBusy",     l, 32'(laneBusy[l]), 32'd0);
            checkOutput("rstDone",     l, 32'(laneDone[l]), 32'd0);
            checkOutput("rstEmpty",    l, 32'(laneEmpty[l]), 32'd0);
            checkOutput("rstMaxValue", l, laneMaxValue[l], 32'd0);
            checkOutput("rstMaxIndex", l, 32'(laneMaxIndex[l]), 32'd0);
            checkOutput("rstRdAddr",   l, 32'(laneRdAddr[l]), 32'd0);
        end
    endtask

    task automatic checkHeld(input logic [31:0] val, input logic [9:0] idx);
        for (int l = 0; l < NLANE; l++) begin
            checkOutput("holdValue", l, laneMaxValue[l], val);
            checkOutput("holdIndex", l, 32'(laneMaxIndex[l]), 32'(idx));
            checkOutput("holdBusy",  l, 32'(laneBusy[l]), 32'd0);
        end
    endtask

    initial begin
        resetN   = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        baseAddr = '0;
        length   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        repeat (3) @(posedge clock);
        #1;
        checkResetState();
        resetN = 1'b1;

        mem[0] = 32'sd3; mem[1] = -32'sd7; mem[2] = 32'sd5; mem[3] = -32'sd2;
        applyStimulus(10'd0, 11'd4, 4, 1'b1, 32'd7, 10'd1);
        repeat (12) @(posedge clock);

        mem[100] = -32'sd9; mem[101] = 32'sd9; mem[102] = 32'sd4;
        applyStimulus(10'd100, 11'd3, 3, 1'b1, 32'd9, 10'd0);
        repeat (11) @(posedge clock);

        applyStimulus(10'd5, 11'd0, 0, 1'b1, 32'd0, 10'd0);
        repeat (4) @(posedge clock);

        mem[1022] = 32'sd1; mem[1023] = -32'sd3; mem[0] = 32'h8000_0000; mem[1] = -32'sd5;
        applyStimulus(10'd1022, 11'd4, 4, 1'b1, 32'h7FFF_FFFF, 10'd2);
        repeat (12) @(posedge clock);

        applyStimulus(10'd200, 11'd5, 5, 1'b1, 32'd0, 10'd0);
        repeat (13) @(posedge clock);

        mem[300] = 32'sd1; mem[301] = 32'sd2; mem[302] = 32'sd3;
        mem[303] = 32'sd4; mem[304] = 32'sd5; mem[305] = -32'sd6;
        applyStimulus(10'd300, 11'd6, 6, 1'b1, 32'd6, 10'd5);
        @(posedge clock);
        #1;
        start = 1'b1; baseAddr = 10'd0; length = 11'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clock);

        mem[400] = 32'sd10;  mem[401] = -32'sd20;  mem[402] = 32'sd300; mem[403] = -32'sd40;
        mem[404] = 32'sd50;  mem[405] = -32'sd299; mem[406] = 32'sd70;  mem[407] = -32'sd300;
        applyStimulus(10'd400, 11'd8, 2, 1'b0, 32'd0, 10'd0);
        @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        checkHeld(32'd6, 10'd5);

        applyStimulus(10'd400, 11'd8, 8, 1'b1, 32'd300, 10'd2);
        repeat (16) @(posedge clock);

        @(posedge clock);
        #1;
        start = 1'b1; abort = 1'b1; baseAddr = 10'd0; length = 11'd4;
        @(posedge clock);
        #1;
        start = 1'b0; abort = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        checkHeld(32'd300, 10'd2);

        applyStimulus(10'd500, 11'd8, 1, 1'b0, 32'd0, 10'd0);
        @(posedge clock);
        #1;
        resetN = 1'b0;
        #2;
        checkResetState();
        @(posedge clock);
        #1;
        resetN = 1'b1;
        repeat (8) @(posedge clock);

        applyStimulus(10'd0, 11'd4, 4, 1'b1, 32'h7FFF_FFFF, 10'd0);
        repeat (14) @(posedge clock);
        #1;

        for (int l = 0; l < NLANE; l++) begin
            checkOutput("pendingDone",  l, 32'(expQ[l].size()), 32'd0);
            checkOutput("pendingReads", l, 32'(addrQ[l].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
